// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch PC sequencer and IF/ID register with halt detection
//
// Ports:
//   CLK          in   1   pipeline clock, rising edge
//   Reset        in   1   asynchronous active-high reset
//   stall        in   1   load-use hold from hazard unit
//   redirect     in   1   taken branch/jal resolved in EX
//   redirect_pc  in  32   redirect target (low two bits ignored)
//   instr        in  32   instruction memory data for curPC
//   curPC        out 32   fetch address
//   id_pc        out 32   PC of instruction in IF/ID
//   id_instr     out 32   instruction in IF/ID
//   id_valid     out  1   IF/ID holds a real instruction
//   halted       out  1   fetch is in the HALT state
module fetch_ctrl #(
    parameter logic [31:0] NOP        = 32'h0000_0013,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0063
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr,
    output logic [31:0] curPC,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= FETCH;
            pc_q       <= 32'h0;
            id_pc_q    <= 32'h0;
            id_instr_q <= NOP;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
        end
    end

    // Priority: redirect > stall > halt detection > normal fetch.
    // Defaults hold everything, which is exactly the stall behaviour.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        id_valid_d = id_valid_q;

        if (redirect) begin
            // Redirect also cancels a HALT entered on a wrong path.
            state_d    = FETCH;
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_pc_d    = 32'h0;
            id_instr_d = NOP;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                FETCH: begin
                    id_instr_d = instr;
                    id_pc_d    = pc_q;
                    id_valid_d = 1'b1;
                    if (instr == HALT_INSTR) begin
                        // The halt instruction itself retires into IF/ID; the
                        // PC stays on it so the halt point is observable.
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 32'd4;  // wraps modulo 2^32
                    end
                end
                HALT: begin
                    id_pc_d    = 32'h0;
                    id_instr_d = NOP;
                    id_valid_d = 1'b0;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign curPC    = pc_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;
    assign id_valid = id_valid_q;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0063;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] curPC;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        halted;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .curPC       (curPC),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_valid    (id_valid),
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] ins, input logic vld, input logic hlt);
        check_eq({tag, ".curPC"},    curPC,    pc);
        check_eq({tag, ".id_pc"},    id_pc,    ipc);
        check_eq({tag, ".id_instr"}, id_instr, ins);
        check_eq({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, vld});
        check_eq({tag, ".halted"},   {31'b0, halted},   {31'b0, hlt});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr       = 32'h0080_0093;
        #2;
        check_all("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0);
        step();
        check_all("reset_held", 32'h0, 32'h0, NOP, 1'b0, 1'b0);
        Reset = 1'b0;

        // Sequential fetch
        step();
        check_all("fetch0", 32'h4, 32'h0, 32'h0080_0093, 1'b1, 1'b0);
        instr = 32'h0020_0113;
        step();
        check_all("fetch1", 32'h8, 32'h4, 32'h0020_0113, 1'b1, 1'b0);

        // Two-cycle stall at curPC = 8
        instr = 32'h0030_0193;
        stall = 1'b1;
        step();
        check_all("stall1", 32'h8, 32'h4, 32'h0020_0113, 1'b1, 1'b0);
        step();
        check_all("stall2", 32'h8, 32'h4, 32'h0020_0113, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        check_all("resume", 32'hC, 32'h8, 32'h0030_0193, 1'b1, 1'b0);

        // Halt encoding under stall is not detected until stall drops
        instr = HALT;
        stall = 1'b1;
        step();
        check_all("halt_stalled", 32'hC, 32'h8, 32'h0030_0193, 1'b1, 1'b0);
        stall = 1'b0;
        step();
        check_all("halt_after_stall", 32'hC, 32'hC, HALT, 1'b1, 1'b1);

        // Redirect with simultaneous stall, cancelling HALT; target low bits dropped
        redirect    = 1'b1;
        redirect_pc = 32'h0000_004A;
        stall       = 1'b1;
        step();
        check_all("redir_stall", 32'h48, 32'h0, NOP, 1'b0, 1'b0);
        redirect = 1'b0;
        stall    = 1'b0;

        // Walk to 0x50 and halt there
        instr = 32'h0000_0093;
        step();
        check_all("walk48", 32'h4C, 32'h48, 32'h0000_0093, 1'b1, 1'b0);
        instr = 32'h0000_0113;
        step();
        check_all("walk4c", 32'h50, 32'h4C, 32'h0000_0113, 1'b1, 1'b0);
        instr = HALT;
        step();
        check_all("halt50", 32'h50, 32'h50, HALT, 1'b1, 1'b1);
        instr = 32'h0000_0193;
        step();
        check_all("halted_bubble1", 32'h50, 32'h0, NOP, 1'b0, 1'b1);
        step();
        check_all("halted_bubble2", 32'h50, 32'h0, NOP, 1'b0, 1'b1);

        // Redirect out of HALT
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0020;
        step();
        check_all("halt_redir", 32'h20, 32'h0, NOP, 1'b0, 1'b0);
        redirect = 1'b0;
        instr    = 32'h0000_0213;
        step();
        check_all("post_redir", 32'h24, 32'h20, 32'h0000_0213, 1'b1, 1'b0);

        // PC wrap modulo 2^32
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        check_all("redir_top", 32'hFFFF_FFFC, 32'h0, NOP, 1'b0, 1'b0);
        redirect = 1'b0;
        instr    = 32'h0000_0293;
        step();
        check_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0000_0293, 1'b1, 1'b0);

        // Reach halted at 0x30 then async reset between edges
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0030;
        step();
        redirect = 1'b0;
        instr    = HALT;
        step();
        check_all("halt30", 32'h30, 32'h30, HALT, 1'b1, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check_all("async_reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0);
        Reset = 1'b0;
        instr = 32'h0080_0093;
        step();
        check_all("after_reset", 32'h4, 32'h0, 32'h0080_0093, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port CLK  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port stall  input  1  load-use hold request from hazard unit.
REQ-004 SHALL have port redirect  input  1  taken branch/jal resolved in EX.
REQ-005 SHALL have port redirect_pc  input  32  target PC for redirect.
REQ-006 SHALL have port instr  input  32  instruction word from instruction memory for curPC, valid before next rising edge.
REQ-007 SHALL have port curPC  output  32  fetch address to instruction memory.
REQ-008 SHALL have port id_pc  output  32  PC of instruction held in IF/ID.
REQ-009 SHALL have port id_instr  output  32  instruction held in IF/ID.
REQ-010 SHALL have port id_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-011 SHALL have port halted  output  1  fetch halted state indicator.
REQ-012 SHALL define parameter NOP, default 32'h00000013, bubble encoding (addi x0,x0,0).
REQ-013 SHALL define parameter HALT_INSTR, default 32'h00000063, halt encoding (beq x0,x0,0).

Function
REQ-014 SHALL implement two states, FETCH and HALT; halted = 1 exactly when state is HALT.
REQ-015 SHALL evaluate per rising edge with priority redirect > stall > halt detection > normal fetch.
REQ-016 On redirect (any state): curPC <= {redirect_pc[31:2],2'b00}; id_instr <= NOP; id_pc <= 0; id_valid <= 0; state <= FETCH.
REQ-017 On stall without redirect: curPC, id_pc, id_instr, id_valid, state all hold.
REQ-018 Normal fetch (FETCH, no redirect, no stall, instr != HALT_INSTR): id_instr <= instr; id_pc <= curPC; id_valid <= 1; curPC <= curPC + 4.
REQ-019 Halt detection (FETCH, no redirect, no stall, instr == HALT_INSTR): id_instr <= instr; id_pc <= curPC; id_valid <= 1; curPC holds; state <= HALT.
REQ-020 In HALT without redirect/stall: curPC holds; id_instr <= NOP; id_pc <= 0; id_valid <= 0.
REQ-021 curPC increment SHALL be modulo 2^32 (32'hFFFFFFFC + 4 -> 0).
REQ-022 Fetch-to-IF/ID latency SHALL be one clock: instr presented for curPC = A appears on id_instr with id_pc = A after the next rising edge.
REQ-023 Redirect SHALL override a simultaneous stall and SHALL cancel a HALT entered on a wrong path.
REQ-024 A halt encoding arriving while stall is high SHALL NOT be detected until the edge on which stall is low.
REQ-025 Outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Reset
REQ-026 While Reset is high, immediately and independent of CLK: curPC = 0, id_pc = 0, id_instr = NOP, id_valid = 0, state = FETCH, halted = 0.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALT SHALL take effect immediately; first fetch after release uses curPC = 0.

Verification
REQ-028 Reset release, instr stream 0x00800093, 0x00200113 -> curPC 0,4,8 on successive edges; id_pc 0 then 4; id_valid 1 after first edge.
REQ-029 stall high two cycles at curPC = 8 -> curPC stays 8, id_pc/id_instr unchanged for both cycles; resumes with curPC = 12.
REQ-030 redirect = 1, redirect_pc = 0x0000004A, stall = 1 same edge -> curPC = 0x48, id_instr = 0x00000013, id_valid = 0.
REQ-031 instr = 0x00000063 at curPC = 0x50 -> id_instr = 0x00000063, id_pc = 0x50, halted = 1, curPC holds 0x50; following edges id_valid = 0, id_instr = NOP.
REQ-032 In HALT, redirect = 1, redirect_pc = 0x20 -> halted = 0, curPC = 0x20, next edge fetches normally to 0x24.
REQ-033 Reset pulse asserted between edges while curPC = 0x30 and halted = 1 -> outputs reach reset values before next edge; curPC = 0.
